trap_ctrl: RTL and testbench

- Trap/interrupt controller feeding the next-PC stage.
- Collects synchronous exceptions from EX (illegal instruction, ecall), an internal machine timer and the trap-return instruction.
- Arbitrates these into one registered trap request with a 3-bit cause code.
- Tracks the exception level and holds the request until the PC stage accepts it.

---
 rtl/trap_ctrl.sv | 166 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/interrupt controller feeding the next-PC stage.
// Arbitrates EX exceptions, machine timer and trap-return into one
// registered request with a 3-bit cause, and tracks exception level.
// Ports:
//   clk, rstn               clock, synchronous active-low reset
//   pc_write                PC stage accepts the pending request
//   illegal_ex, ecall_ex    synchronous exceptions from EX
//   ret_ex                  trap-return in EX
//   ie                      global enable for the timer interrupt
//   cmp_we, cmp_wdata       mtimecmp write port
//   int_signal, int_pend    trap request and its cause
//   int_ret                 return request (next PC = EPC + 4)
//   exl_set                 exception level (in handler)
//   flush                   one-cycle pipeline flush on acceptance
//   mtime                   current timer value
module trap_ctrl #(
   parameter int unsigned PRESCALE = 16,
   parameter int unsigned TIMER_W  = 32
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               pc_write,
   input  logic               illegal_ex,
   input  logic               ecall_ex,
   input  logic               ret_ex,
   input  logic               ie,
   input  logic               cmp_we,
   input  logic [TIMER_W-1:0] cmp_wdata,
   output logic               int_signal,
   output logic [2:0]         int_pend,
   output logic               int_ret,
   output logic               exl_set,
   output logic               flush,
   output logic [TIMER_W-1:0] mtime
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   localparam logic [2:0] C_NONE    = 3'b000;
   localparam logic [2:0] C_TIMER   = 3'b001;
   localparam logic [2:0] C_ILLEGAL = 3'b010;
   localparam logic [2:0] C_ECALL   = 3'b011;

   typedef enum logic [1:0] {
      S_RUN,
      S_TRAP,
      S_HANDLER,
      S_RET
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [TIMER_W-1:0] mtime_q, mtime_d;
   logic [TIMER_W-1:0] mtimecmp_q, mtimecmp_d;
   logic               int_signal_q, int_signal_d;
   logic [2:0]         int_pend_q, int_pend_d;
   logic               int_ret_q, int_ret_d;
   logic               exl_set_q, exl_set_d;
   logic               flush_q, flush_d;
   logic               timer_pend;

   // Level-sensitive: stays set until software moves mtimecmp.
   assign timer_pend = (mtime_q >= mtimecmp_q);

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      mtime_d      = mtime_q;
      mtimecmp_d   = mtimecmp_q;
      int_signal_d = int_signal_q;
      int_pend_d   = int_pend_q;
      int_ret_d    = int_ret_q;
      exl_set_d    = exl_set_q;
      flush_d      = 1'b0;

      if (presc_q == PS_LAST) begin
         presc_d = '0;
         mtime_d = mtime_q + TIMER_W'(1);
      end else begin
         presc_d = presc_q + PW'(1);
      end

      if (cmp_we) begin
         mtimecmp_d = cmp_wdata;
      end

      case (state_q)
         S_RUN: begin
            // ret_ex is meaningless outside a handler and is dropped.
            if (illegal_ex) begin
               int_signal_d = 1'b1;
               int_pend_d   = C_ILLEGAL;
               state_d      = S_TRAP;
            end else if (ecall_ex) begin
               int_signal_d = 1'b1;
               int_pend_d   = C_ECALL;
               state_d      = S_TRAP;
            end else if (timer_pend && ie) begin
               int_signal_d = 1'b1;
               int_pend_d   = C_TIMER;
               state_d      = S_TRAP;
            end
         end
         S_TRAP: begin
            if (pc_write) begin
               int_signal_d = 1'b0;
               int_pend_d   = C_NONE;
               exl_set_d    = 1'b1;
               flush_d      = 1'b1;
               state_d      = S_HANDLER;
            end
         end
         S_HANDLER: begin
            // No nesting: exceptions and timer are masked here.
            if (ret_ex) begin
               int_ret_d = 1'b1;
               state_d   = S_RET;
            end
         end
         S_RET: begin
            if (pc_write) begin
               int_ret_d = 1'b0;
               exl_set_d = 1'b0;
               flush_d   = 1'b1;
               state_d   = S_RUN;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= S_RUN;
         presc_q      <= '0;
         mtime_q      <= '0;
         mtimecmp_q   <= '1;
         int_signal_q <= 1'b0;
         int_pend_q   <= C_NONE;
         int_ret_q    <= 1'b0;
         exl_set_q    <= 1'b0;
         flush_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         mtime_q      <= mtime_d;
         mtimecmp_q   <= mtimecmp_d;
         int_signal_q <= int_signal_d;
         int_pend_q   <= int_pend_d;
         int_ret_q    <= int_ret_d;
         exl_set_q    <= exl_set_d;
         flush_q      <= flush_d;
      end
   end

   assign int_signal = int_signal_q;
   assign int_pend   = int_pend_q;
   assign int_ret    = int_ret_q;
   assign exl_set    = exl_set_q;
   assign flush      = flush_q;
   assign mtime      = mtime_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_trap_ctrl;

   localparam int unsigned PA = 1;
   localparam int unsigned WA = 32;
   localparam int unsigned PB = 16;
   localparam int unsigned WB = 8;
   localparam longint MOD = 64'h1_0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn = 1'b0;
   logic          pc_write = 1'b0;
   logic          illegal_ex = 1'b0;
   logic          ecall_ex = 1'b0;
   logic          ret_ex = 1'b0;
   logic          ie = 1'b0;
   logic          cmp_we = 1'b0;
   logic [WA-1:0] cmp_wdata = '0;
   logic          int_signal;
   logic [2:0]    int_pend;
   logic          int_ret;
   logic          exl_set;
   logic          flush;
   logic [WA-1:0] mtime;

   logic          rstn_b = 1'b0;
   logic [WB-1:0] cmp_wdata_b = '0;
   logic          int_signal_b;
   logic [2:0]    int_pend_b;
   logic          int_ret_b;
   logic          exl_set_b;
   logic          flush_b;
   logic [WB-1:0] mtime_b;

   trap_ctrl #(.PRESCALE(PA), .TIMER_W(WA)) dut (
      .clk(clk), .rstn(rstn), .pc_write(pc_write),
      .illegal_ex(illegal_ex), .ecall_ex(ecall_ex),
      .ret_ex(ret_ex), .ie(ie), .cmp_we(cmp_we),
      .cmp_wdata(cmp_wdata), .int_signal(int_signal),
      .int_pend(int_pend), .int_ret(int_ret),
      .exl_set(exl_set), .flush(flush), .mtime(mtime)
   );

   trap_ctrl #(.PRESCALE(PB), .TIMER_W(WB)) dut_b (
      .clk(clk), .rstn(rstn_b), .pc_write(1'b0),
      .illegal_ex(1'b0), .ecall_ex(1'b0),
      .ret_ex(1'b0), .ie(1'b0), .cmp_we(1'b0),
      .cmp_wdata(cmp_wdata_b), .int_signal(int_signal_b),
      .int_pend(int_pend_b), .int_ret(int_ret_b),
      .exl_set(exl_set_b), .flush(flush_b), .mtime(mtime_b)
   );

   wire [6:0] outs = {int_signal, int_pend, int_ret, exl_set, flush};

   int n_checks = 0;
   int n_fail = 0;

   // Behavioural model: output bits themselves are the state.
   longint e_time, e_cmp;
   int     e_div, e_pend;
   bit     e_sig, e_ret, e_exl, e_flush;

   function automatic void model_step();
      bit tp;
      int cause;
      if (!rstn) begin
         e_time = 0; e_cmp = MOD - 1; e_div = 0;
         e_sig = 0; e_pend = 0; e_ret = 0;
         e_exl = 0; e_flush = 0;
         return;
      end
      tp = (e_time >= e_cmp);
      e_flush = 0;
      if (e_sig) begin
         if (pc_write) begin
            e_sig = 0; e_pend = 0; e_exl = 1; e_flush = 1;
         end
      end else if (e_ret) begin
         if (pc_write) begin
            e_ret = 0; e_exl = 0; e_flush = 1;
         end
      end else if (e_exl) begin
         if (ret_ex) e_ret = 1;
      end else begin
         cause = 0;
         if (illegal_ex) cause = 2;
         else if (ecall_ex) cause = 3;
         else if (tp && ie) cause = 1;
         if (cause != 0) begin
            e_sig = 1; e_pend = cause;
         end
      end
      e_div++;
      if (e_div == int'(PA)) begin
         e_div = 0;
         e_time = (e_time + 1) % MOD;
      end
      if (cmp_we) e_cmp = longint'(cmp_wdata);
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; rstn_b = 1'b0;
      ie = 1'b1; pc_write = 1'b1; illegal_ex = 1'b1;
      tick();
      illegal_ex = 1'b0;
      n_checks++;
      if (outs !== 7'b0 || mtime !== '0) begin
         n_fail++;
         $display("FAIL reset outs=%b mtime=%0d exp 0/0", outs, mtime);
      end
      n_checks++;
      if (mtime_b !== '0 || int_signal_b !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_b mtime=%0d sig=%b exp 0/0",
                  mtime_b, int_signal_b);
      end
   endtask

   task automatic test_timer();
      int waited;
      rstn = 1'b0; ie = 1'b1; pc_write = 1'b1;
      tick();
      rstn = 1'b1; cmp_we = 1'b1; cmp_wdata = 5;
      tick();
      cmp_we = 1'b0;
      waited = 0;
      while (!int_signal && waited < 20) begin
         tick();
         waited++;
      end
      n_checks++;
      if (outs !== 7'b1_001_0_0_0 || mtime !== 6) begin
         n_fail++;
         $display("FAIL timer_req outs=%b mtime=%0d exp 1001000/6",
                  outs, mtime);
      end
      tick();
      n_checks++;
      if (outs !== 7'b0_000_0_1_1) begin
         n_fail++;
         $display("FAIL timer_accept outs=%b exp 0000011", outs);
      end
      tick();
      n_checks++;
      if (outs !== 7'b0_000_0_1_0) begin
         n_fail++;
         $display("FAIL timer_flush1 outs=%b exp 0000010", outs);
      end
      cmp_we = 1'b1; cmp_wdata = '1; ret_ex = 1'b1;
      tick();
      cmp_we = 1'b0; ret_ex = 1'b0;
      n_checks++;
      if (outs !== 7'b0_000_1_1_0) begin
         n_fail++;
         $display("FAIL timer_ret outs=%b exp 0000110", outs);
      end
      tick();
      n_checks++;
      if (outs !== 7'b0_000_0_0_1) begin
         n_fail++;
         $display("FAIL timer_retacc outs=%b exp 0000001", outs);
      end
      tick();
      tick();
      n_checks++;
      if (outs !== 7'b0) begin
         n_fail++;
         $display("FAIL timer_cleared outs=%b exp 0000000", outs);
      end
   endtask

   task automatic test_simul();
      pc_write = 1'b0; illegal_ex = 1'b1; ecall_ex = 1'b1;
      tick();
      illegal_ex = 1'b0; ecall_ex = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (outs !== 7'b1_010_0_0_0) begin
            n_fail++;
            $display("FAIL simul_hold%0d outs=%b exp 1010000", i, outs);
         end
         if (i < 3) tick();
      end
      pc_write = 1'b1;
      tick();
      n_checks++;
      if (outs !== 7'b0_000_0_1_1) begin
         n_fail++;
         $display("FAIL simul_accept outs=%b exp 0000011", outs);
      end
   endtask

   task automatic test_handler_mask();
      ie = 1'b1; pc_write = 1'b0;
      cmp_we = 1'b1; cmp_wdata = '0; ecall_ex = 1'b1;
      tick();
      cmp_we = 1'b0;
      tick();
      n_checks++;
      if (outs !== 7'b0_000_0_1_0) begin
         n_fail++;
         $display("FAIL mask_a outs=%b exp 0000010", outs);
      end
      tick();
      n_checks++;
      if (outs !== 7'b0_000_0_1_0) begin
         n_fail++;
         $display("FAIL mask_b outs=%b exp 0000010", outs);
      end
      ecall_ex = 1'b0; ret_ex = 1'b1;
      tick();
      ret_ex = 1'b0;
      n_checks++;
      if (outs !== 7'b0_000_1_1_0) begin
         n_fail++;
         $display("FAIL mask_ret outs=%b exp 0000110", outs);
      end
      pc_write = 1'b1;
      tick();
      n_checks++;
      if (outs !== 7'b0_000_0_0_1) begin
         n_fail++;
         $display("FAIL mask_retacc outs=%b exp 0000001", outs);
      end
      tick();
      n_checks++;
      if (outs !== 7'b1_001_0_0_0) begin
         n_fail++;
         $display("FAIL mask_timer outs=%b exp 1001000", outs);
      end
      tick();
      n_checks++;
      if (outs !== 7'b0_000_0_1_1) begin
         n_fail++;
         $display("FAIL mask_timeracc outs=%b exp 0000011", outs);
      end
   endtask

   task automatic test_ret_ignored();
      rstn = 1'b0; ie = 1'b0; pc_write = 1'b1;
      tick();
      rstn = 1'b1; ret_ex = 1'b1;
      tick();
      n_checks++;
      if (outs !== 7'b0) begin
         n_fail++;
         $display("FAIL retign_a outs=%b exp 0000000", outs);
      end
      tick();
      n_checks++;
      if (outs !== 7'b0) begin
         n_fail++;
         $display("FAIL retign_b outs=%b exp 0000000", outs);
      end
      ret_ex = 1'b0; illegal_ex = 1'b1; pc_write = 1'b0;
      tick();
      illegal_ex = 1'b0;
      n_checks++;
      if (outs !== 7'b1_010_0_0_0) begin
         n_fail++;
         $display("FAIL retign_run outs=%b exp 1010000", outs);
      end
   endtask

   task automatic test_mid_reset();
      tick();
      rstn = 1'b0;
      tick();
      n_checks++;
      if (outs !== 7'b0 || mtime !== '0) begin
         n_fail++;
         $display("FAIL midrst outs=%b mtime=%0d exp 0/0", outs, mtime);
      end
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (outs !== 7'b0) begin
            n_fail++;
            $display("FAIL midrst_idle%0d outs=%b exp 0000000", i, outs);
         end
      end
   endtask

   task automatic test_prescale();
      int waited;
      bit seen;
      rstn_b = 1'b0;
      tick();
      rstn_b = 1'b1;
      repeat (160) tick();
      n_checks++;
      if (mtime_b !== 8'd10) begin
         n_fail++;
         $display("FAIL presc_160 mtime=%0d exp 10", mtime_b);
      end
      seen = 1'b0;
      waited = 0;
      while (mtime_b !== 8'hFF && waited < 5000) begin
         tick();
         waited++;
         if (int_signal_b) seen = 1'b1;
      end
      repeat (16) begin
         tick();
         if (int_signal_b) seen = 1'b1;
      end
      n_checks++;
      if (mtime_b !== 8'd0) begin
         n_fail++;
         $display("FAIL presc_wrap mtime=%0d exp 0", mtime_b);
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL presc_spurious sig_seen=%b exp 0", seen);
      end
   endtask

   task automatic test_random();
      bit prev_flush;
      logic [WA+6:0] exp_v;
      rstn = 1'b0;
      tick();
      prev_flush = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rstn       = ($urandom_range(0, 199) != 0);
         illegal_ex = ($urandom_range(0, 7) == 0);
         ecall_ex   = ($urandom_range(0, 7) == 0);
         ret_ex     = ($urandom_range(0, 3) == 0);
         pc_write   = ($urandom_range(0, 1) == 0);
         ie         = ($urandom_range(0, 1) == 0);
         cmp_we     = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) cmp_wdata = '1;
         else cmp_wdata = WA'($urandom_range(0, 4000));
         tick();
         exp_v = {e_sig, 3'(e_pend), e_ret, e_exl, e_flush,
                  WA'(e_time)};
         n_checks++;
         if ({outs, mtime} !== exp_v) begin
            n_fail++;
            $display("FAIL rand%0d got %b/%0d exp %b/%0d", i, outs,
                     mtime, exp_v[WA+6:WA], exp_v[WA-1:0]);
         end
         n_checks++;
         if ((int_signal && int_ret) || (prev_flush && flush)) begin
            n_fail++;
            $display("FAIL rand_inv%0d sig=%b ret=%b flush=%b%b exp no overlap",
                     i, int_signal, int_ret, prev_flush, flush);
         end
         prev_flush = flush;
      end
      rstn = 1'b1; illegal_ex = 1'b0; ecall_ex = 1'b0;
      ret_ex = 1'b0; cmp_we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_timer();
      test_simul();
      test_handler_mask();
      test_ret_ignored();
      test_mid_reset();
      test_prescale();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
